// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer and fetch controller feeding the IF/ID register.
// Sends in-order word fetches to instruction memory, buffers the returned
// words with their PCs, and presents one {pc, instruction} pair per cycle.
// A redirect drops wrong-path work and flushes IF/ID in the same cycle.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_req_valid/ready/addr  fetch request channel (word-aligned address)
//   imem_rsp_valid/data        in-order responses, no backpressure
//   redirect_valid/pc          taken branch/jump from execute
//   stall                      hazard unit holds the IF/ID register
//   pc, instruction, out_valid pair presented to IF/ID
//   flush                      IF/ID flush, equal to redirect_valid
//
// Optional feature macro FETCH_PERF_EN adds perf_stall_cycles and
// perf_killed_rsp counters (32-bit, wrapping).
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        out_valid,
  output logic        flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_killed_rsp
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   kill_q, kill_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        buf_pc_q  [DEPTH];
  logic [31:0]        buf_ins_q [DEPTH];

  logic               empty;
  logic               credit_ok;
  logic [CNT_W:0]     credit_used;
  logic               req_fire;
  logic               push;
  logic               pop;
  logic               discard;
  logic [31:0]        target_pc;

  // Low address bits of the redirect target are ignored (word fetches only).
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Handshake, output and event decode.
  always_comb begin
    empty          = (count_q == '0);
    credit_used    = {1'b0, outstanding_q} + {1'b0, count_q};
    credit_ok      = (credit_used < (CNT_W + 1)'(DEPTH));
    imem_req_valid = (state_q != BOOT) && !redirect_valid && credit_ok;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    out_valid      = !empty && !redirect_valid;
    pc             = empty ? 32'h0 : buf_pc_q[rd_ptr_q];
    instruction    = empty ? 32'h0 : buf_ins_q[rd_ptr_q];
    flush          = redirect_valid;
    pop            = out_valid && !stall;
    // A response arriving with a redirect belongs to the wrong path.
    discard        = imem_rsp_valid && (redirect_valid || (kill_q != '0));
    push           = imem_rsp_valid && !discard;
    target_pc      = {redirect_pc[31:2], 2'b00};
  end

  // Next-state logic; redirect overrides every other update.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    kill_d        = kill_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    if (redirect_valid) begin
      pc_d     = target_pc;
      rsp_pc_d = target_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      kill_d   = outstanding_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid && (kill_q != '0)) begin
        kill_d = kill_q - CNT_W'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN,
      DRAIN:   state_d = (kill_d != '0) ? DRAIN : RUN;
      default: state_d = BOOT;
    endcase
  end

  // State registers and buffer storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        buf_pc_q[wr_ptr_q]  <= rsp_pc_q;
        buf_ins_q[wr_ptr_q] <= imem_rsp_data;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_killed_q;

  // Stall-while-valid cycles and discarded responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q  <= '0;
      perf_killed_q <= '0;
    end else begin
      if (out_valid && stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (discard) begin
        perf_killed_q <= perf_killed_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_killed_rsp   = perf_killed_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a behavioural
// instruction memory of programmable latency.
module tb_fetch_ctrl;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        out_valid;
  logic        flush;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_killed_rsp;
`endif

  fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .pc             (pc),
    .instruction    (instruction),
    .out_valid      (out_valid),
    .flush          (flush)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_killed_rsp   (perf_killed_rsp)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pops     = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Expected output stream starting at base.
  function automatic void set_stream(input logic [31:0] base);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 48; i++) begin
      e.pc  = base + 32'(4 * i);
      e.ins = mem_word(e.pc);
      exp_q.push_back(e);
    end
    pops = 0;
  endfunction

  // Instruction memory: response appears lat cycles after the accepting edge.
  int          lat = 1;
  int          cyc = 0;
  int          inflight = 0;
  logic        pend_v [16];
  logic [31:0] pend_d [16];
  logic        rst_s;

  initial begin
    for (int i = 0; i < 16; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = 32'h0;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      rst_s = rst_n;
      cyc++;
      #1;
      if (!rst_s) begin
        for (int i = 0; i < 16; i++) pend_v[i] = 1'b0;
        inflight = 0;
      end
      imem_rsp_valid = pend_v[cyc % 16];
      imem_rsp_data  = pend_v[cyc % 16] ? pend_d[cyc % 16] : 32'h0;
      if (pend_v[cyc % 16]) begin
        pend_v[cyc % 16] = 1'b0;
        inflight--;
      end
      #1;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        pend_v[(cyc + lat) % 16] = 1'b1;
        pend_d[(cyc + lat) % 16] = mem_word(imem_req_addr);
        inflight++;
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard compare on each pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("inflight_bound", 32'(inflight <= int'(DEPTH)), 32'd1);
        chk("flush_eq_redirect", 32'(flush), 32'(redirect_valid));
        if (redirect_valid) begin
          chk("redir_no_out", 32'(out_valid), 32'd0);
          chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        end
        if (out_valid && !stall) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_out", pc, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_instr", instruction, e.ins);
            pops++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instruction, 32'h0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_stall"}, perf_stall_cycles, 32'd0);
    chk({tag, "_perf_killed"}, perf_killed_rsp, 32'd0);
`endif
  endtask

  // Asserts reset now, checks the held and BOOT states, returns in cycle 0.
  task automatic do_reset(input int new_lat);
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    #2;
    chk_idle("rst_hold");
    lat = new_lat;
    step();
    rst_n = 1'b1;
    set_stream(RESET_PC);
    #2;
    chk_idle("rst_boot");
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (pops < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("pop_count_reached", 32'(pops >= n), 32'd1);
  endtask

  initial begin
    logic        exp_rv   [3];
    logic [31:0] exp_addr [3];
    logic        exp_ov   [3];
    exp_rv   = '{1'b1, 1'b1, 1'b0};
    exp_addr = '{32'h0, 32'h4, 32'h8};
    exp_ov   = '{1'b0, 1'b0, 1'b1};
    imem_req_ready = 1'b1;

    // Streaming from reset with single-cycle memory.
    do_reset(1);
    for (int c = 0; c < 3; c++) begin
      step();
      #2;
      chk("boot_req_valid", 32'(imem_req_valid), 32'(exp_rv[c]));
      chk("boot_req_addr", imem_req_addr, exp_addr[c]);
      chk("boot_out_valid", 32'(out_valid), 32'(exp_ov[c]));
    end
    step();

    // Stall five cycles; the buffer fills and the head holds at 0x8.
    step();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      #2;
      if (k >= 1) begin
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_head_pc", pc, 32'h8);
        chk("stall_head_instr", instruction, mem_word(32'h8));
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      end
    end
    step();
    stall = 1'b0;
`ifdef FETCH_PERF_EN
    #2;
    chk("perf_stall_count", perf_stall_cycles, 32'd4);
`endif
    wait_pops(12, 100);

    // Unaligned redirect target is word-aligned.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    set_stream(32'h200);
    #2;
    chk("redir203_flush", 32'(flush), 32'd1);
    step();
    redirect_valid = 1'b0;
    #2;
    chk("redir203_req_valid", 32'(imem_req_valid), 32'd1);
    chk("redir203_req_addr", imem_req_addr, 32'h200);
    chk("redir203_out_valid", 32'(out_valid), 32'd0);
    wait_pops(6, 100);

    // Three-cycle memory, redirect with two requests outstanding.
    do_reset(3);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    set_stream(32'h100);
    #2;
    chk("lat3_flush", 32'(flush), 32'd1);
    step();
    redirect_valid = 1'b0;
    #2;
    chk("lat3_no_credit", 32'(imem_req_valid), 32'd0);
    step();
    #2;
    chk("lat3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("lat3_req_addr", imem_req_addr, 32'h100);
    wait_pops(4, 200);

    // Redirect together with stall, a response and a non-empty buffer.
    do_reset(1);
    for (int c = 0; c < 4; c++) step();
    step();
    stall = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    set_stream(32'h300);
    #2;
    chk("mix_rsp_present", 32'(imem_rsp_valid), 32'd1);
    chk("mix_flush", 32'(flush), 32'd1);
    step();
    redirect_valid = 1'b0;
    #2;
    chk("mix_empty_valid", 32'(out_valid), 32'd0);
    chk("mix_empty_pc", pc, 32'h0);
    chk("mix_empty_instr", instruction, 32'h0);
    chk("mix_req_valid", 32'(imem_req_valid), 32'd1);
    chk("mix_req_addr", imem_req_addr, 32'h300);
    step();
    stall = 1'b0;
    wait_pops(4, 100);

    // Reset while draining one stale response.
    do_reset(3);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    set_stream(32'h100);
    step();
    redirect_valid = 1'b0;
    step();
    #2;
    chk("drain_no_out", 32'(out_valid), 32'd0);
`ifdef FETCH_PERF_EN
    chk("drain_perf_killed", perf_killed_rsp, 32'd1);
`endif
    do_reset(1);
    wait_pops(5, 100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
